setuphold_bist_ctrl: RTL and testbench

Self-test sequencer for a single-bit register under test (RUT) in the setup/hold gate-level studies. It launches a pattern into the RUT data input one bit per clock, realigns the expected bit with the RUT's capture latency, and compares against the RUT output. It reports mismatch count, first failing vector index and pass/fail. It sits beside the SDF-annotated flop so that timing violations show up as counted bit errors rather than only as simulator warnings.

---
 rtl/setuphold_pkg.sv | 9 +
 rtl/bist_lfsr.sv | 19 +
 rtl/setuphold_bist_ctrl.sv | 113 +++++++++++
 tb/tb_setuphold_bist_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/setuphold_pkg.sv
// setuphold_pkg: shared state type, LFSR constants and step function for the setup/hold BIST
package setuphold_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_t;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {^(s & LFSR_TAPS), s[7:1]};
  endfunction
endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr: 8-bit Fibonacci LFSR; on load the seed bit is presented and stepped past in the same cycle
module bist_lfsr import setuphold_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] seed,
  output logic       bit_o
);
  logic [7:0] lfsr_q, lfsr_d, cur;
  always_comb begin
    cur = load ? seed : lfsr_q;
    lfsr_d = en ? lfsr_step(cur) : cur;
  end
  assign bit_o = cur[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= DEFAULT_SEED;
    else lfsr_q <= lfsr_d;
endmodule

// File: rtl/setuphold_bist_ctrl.sv
// setuphold_bist_ctrl: launches a pattern into a 1-bit RUT, realigns expected bits by CAP_LAT
// and counts mismatches against q_in, reporting first failing index and pass/fail.
module setuphold_bist_ctrl import setuphold_pkg::*; #(
  parameter int         N_VECTORS = 16,
  parameter int         CAP_LAT   = 1,
  parameter int         ERR_W     = 8,
  parameter logic [7:0] SEED      = DEFAULT_SEED
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         mode,
  input  logic                         q_in,
  output logic                         d_out,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [ERR_W-1:0]             err_count,
  output logic [$clog2(N_VECTORS)-1:0] first_err_idx
);
  localparam int IW = $clog2(N_VECTORS);
  localparam int CW = $clog2(CAP_LAT + 1);
  localparam logic [IW-1:0] LAST = IW'(N_VECTORS - 1);
  localparam logic [CW-1:0] DRAIN_END = CW'(CAP_LAT);
  bist_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, cidx_q, cidx_d, fidx_q, fidx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [CAP_LAT-1:0] dl_b_q, dl_b_d, dl_v_q, dl_v_d;
  logic d_out_q, d_out_d, lv_q, lv_d, first_q, first_d;
  logic go, launch, pat, lfsr_bit, cmp_v, mis;

  bist_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (go),
    .en    (launch),
    .seed  (SEED),
    .bit_o (lfsr_bit)
  );

  // idx_q is kept at zero outside RUN so the start cycle launches vector 0
  always_comb begin
    go = start && !abort && (state_q == IDLE || state_q == DONE);
    launch = go || (!abort && state_q == RUN);
    pat = mode ? idx_q[0] : lfsr_bit;
    cmp_v = dl_v_q[CAP_LAT-1];
    mis = cmp_v && (dl_b_q[CAP_LAT-1] != q_in);
    dl_b_d = CAP_LAT'({dl_b_q, d_out_q});
    dl_v_d = CAP_LAT'({dl_v_q, lv_q});
    err_d = (mis && err_q != '1) ? err_q + 1'b1 : err_q;
    first_d = first_q || mis;
    fidx_d = (mis && !first_q) ? cidx_q : fidx_q;
    cidx_d = cidx_q + IW'(cmp_v);
    state_d = state_q;
    idx_d = launch ? idx_q + 1'b1 : idx_q;
    cnt_d = cnt_q;
    d_out_d = launch ? pat : d_out_q;
    lv_d = launch;
    if (abort || go) begin
      state_d = abort ? IDLE : RUN;
      idx_d = abort ? '0 : idx_d;
      d_out_d = abort ? 1'b0 : d_out_d;
      err_d = '0;
      fidx_d = '0;
      first_d = 1'b0;
      cidx_d = '0;
      dl_v_d = '0;
    end else if (state_q == RUN && idx_q == LAST) begin
      state_d = DRAIN;
      idx_d = '0;
      cnt_d = '0;
    end else if (state_q == DRAIN) begin
      state_d = (cnt_q == DRAIN_END) ? DONE : DRAIN;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cidx_q <= '0;
      fidx_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      dl_b_q <= '0;
      dl_v_q <= '0;
      d_out_q <= 1'b0;
      lv_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cidx_q <= cidx_d;
      fidx_q <= fidx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      dl_b_q <= dl_b_d;
      dl_v_q <= dl_v_d;
      d_out_q <= d_out_d;
      lv_q <= lv_d;
      first_q <= first_d;
    end

  assign d_out = d_out_q;
  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = done && (err_q == '0);
  assign err_count = err_q;
  assign first_err_idx = fidx_q;
endmodule

// File: tb/tb_setuphold_bist_ctrl.sv
// tb_setuphold_bist_ctrl: randomized runs against a run-relative timing model of the BIST controller
module tb_setuphold_bist_ctrl;
  localparam int N = 16, CL = 2, EW = 4, IW = $clog2(N), EMAX = (1 << EW) - 1;
  logic clk = 0, rst_n = 1, start = 0, abort = 0, mode = 0, q_in = 0;
  logic d_out, busy, done, pass;
  logic [EW-1:0] err_count;
  logic [IW-1:0] first_err_idx;
  int total = 0, bad = 0;
  bit m_act = 0, m_done = 0, m_dknown = 1;
  int m_rel = 0;
  logic m_vec [N];
  logic m_flip [N];
  logic pend_flip [N];

  setuphold_bist_ctrl #(.N_VECTORS(N), .CAP_LAT(CL), .ERR_W(EW), .SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .q_in(q_in),
    .d_out(d_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // vector i of a run: toggle gives i[0]; LFSR gives bit 0 of the seed after i steps (taps 8,6,5,4)
  function automatic logic pat_bit(input logic m, input int i);
    logic [7:0] s = 8'hA5;
    if (m) return i[0];
    for (int k = 0; k < i; k++) s = {s[7] ^ s[5] ^ s[4] ^ s[3], s[7:1]};
    return s[0];
  endfunction

  // vector i is compared in the cycle with rel == i+CL, so it is counted once rel > i+CL
  function automatic int exp_err();
    int c = 0;
    if (m_act || m_done)
      for (int i = 0; i < N; i++) if (m_flip[i] && i + CL + 1 <= m_rel) c++;
    return c > EMAX ? EMAX : c;
  endfunction

  function automatic int exp_first();
    if (m_act || m_done)
      for (int i = 0; i < N; i++) if (m_flip[i] && i + CL + 1 <= m_rel) return i;
    return 0;
  endfunction

  function automatic int exp_dout();
    if (!(m_act || m_done)) return 0;
    return int'(m_vec[m_rel < N ? m_rel : N - 1]);
  endfunction

  // rel counts edges since the accepted start edge; busy for rel 0..N+CL-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_done = 0; m_rel = 0; m_dknown = 1;
    end else if (abort) begin
      m_act = 0; m_done = 0; m_dknown = 0;
    end else if (start && !m_act) begin
      m_act = 1; m_done = 0; m_rel = 0; m_dknown = 1;
      for (int i = 0; i < N; i++) begin
        m_vec[i] = pat_bit(mode, i);
        m_flip[i] = pend_flip[i];
      end
    end else if (m_act) begin
      m_rel++;
      if (m_rel == N + CL) begin
        m_act = 0; m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_act));
    check("done", int'(done), int'(m_done));
    check("pass", int'(pass), int'(m_done && exp_err() == 0));
    check("err_count", int'(err_count), exp_err());
    check("first_err_idx", int'(first_err_idx), exp_first());
    if (m_dknown) check("d_out", int'(d_out), exp_dout());
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_act && m_rel >= CL && m_rel - CL < N) q_in = m_vec[m_rel-CL] ^ m_flip[m_rel-CL];
    else q_in = 1'($urandom);
  endtask

  // kind: 0 ideal loopback, 1 stuck-at-0, 2 inverted, 3 random bit errors
  task automatic launch(input logic m, input int kind);
    mode = m;
    for (int i = 0; i < N; i++)
      pend_flip[i] = kind == 0 ? 1'b0 : kind == 1 ? pat_bit(m, i) : kind == 2 ? 1'b1 :
                     ($urandom_range(0, 3) == 0);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int extra, output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      start = (lat == extra);
      tick();
      start = 0;
      lat++;
    end
  endtask

  initial begin
    int lat, prefix;
    prefix = 0;
    for (int i = 0; i < 6; i++) prefix |= int'(pat_bit(1'b0, i)) << i;
    check("model_lfsr_prefix", prefix, 37);
    #2 rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err_count), 0);
    check("reset_dout", int'(d_out), 0);
    launch(1'b0, 0);
    wait_done(-1, lat);
    check("loopback_latency", lat, 18);
    check("loopback_err", int'(err_count), 0);
    check("loopback_pass", int'(pass), 1);
    check("loopback_first", int'(first_err_idx), 0);
    launch(1'b1, 1);
    wait_done(-1, lat);
    check("stuck0_err", int'(err_count), 8);
    check("stuck0_first", int'(first_err_idx), 1);
    check("stuck0_pass", int'(pass), 0);
    check("model_err_stuck", exp_err(), 8);
    launch(1'b0, 2);
    wait_done(-1, lat);
    check("invert_err_sat", int'(err_count), 15);
    check("invert_first", int'(first_err_idx), 0);
    launch(1'b0, 2);
    repeat (4) tick();
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_err", int'(err_count), 0);
    check("abort_done", int'(done), 0);
    launch(1'b0, 3);
    wait_done(4, lat);
    check("start_in_busy_latency", lat, 18);
    launch(1'b0, 0);
    wait_done(-1, lat);
    check("reseed_pass", int'(pass), 1);
    launch(1'b1, 2);
    repeat (N) tick();
    check("drain_busy", int'(busy), 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_err", int'(err_count), 0);
    check("async_rst_first", int'(first_err_idx), 0);
    check("async_rst_dout", int'(d_out), 0);
    check("async_rst_done", int'(done), 0);
    tick();
    tick();
    rst_n = 1;
    tick();
    launch(1'b0, 0);
    wait_done(-1, lat);
    check("post_rst_latency", lat, 18);
    check("post_rst_pass", int'(pass), 1);
    for (int r = 0; r < 10; r++) begin
      launch(1'($urandom), 3);
      wait_done($urandom_range(0, 1) == 1 ? int'($urandom_range(1, 15)) : -1, lat);
      check("rand_latency", lat, N + CL);
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
